control_unit: RTL and testbench

- Multi-cycle control unit of the Mano-style mycpu core; sits directly upstream of the datapath and function unit.
- Holds the instruction register and sequences RST/INF/EX0/XL1/HLT (cu_state_t).
- Decodes opcode_t into datapath control signals, including the fs_t function code consumed by the function unit.
- Uses status flags (Z, N) returned by the function unit for branches.

---
 rtl/control_unit.sv | 215 +++++++++++++++++++++
 tb/tb_control_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle control unit for the mycpu core: IR plus RST/INF/EX0/XL1/HLT
// sequencer, decoding opcodes into datapath and function-unit controls.
module control_unit #(
  parameter int IW  = 16,
  parameter int RAW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IW-1:0]  ir_in,
  input  logic           z_in,
  input  logic           n_in,
  output logic [RAW-1:0] da,
  output logic [RAW-1:0] aa,
  output logic [RAW-1:0] ba,
  output logic           mb,
  output logic [3:0]     fs,
  output logic [1:0]     md,
  output logic           rw,
  output logic           mm,
  output logic           mw,
  output logic           io_we,
  output logic           pi,
  output logic           pl,
  output logic           jb,
  output logic           halted,
  output logic           ill_op,
  output logic [3:0]     state_out
);

  typedef enum logic [3:0] {
    S_RST = 4'd0,
    S_INF = 4'd1,
    S_EX0 = 4'd2,
    S_XL1 = 4'd3,
    S_HLT = 4'd4
  } cu_state_t;

  typedef enum logic [6:0] {
    OP_LD  = 7'h10,
    OP_IOR = 7'h11,
    OP_ST  = 7'h20,
    OP_IOW = 7'h21,
    OP_ADI = 7'h42,
    OP_LDI = 7'h4C,
    OP_BRZ = 7'h60,
    OP_BRN = 7'h61,
    OP_JMP = 7'h70,
    OP_XXL = 7'h7E,
    OP_HAL = 7'h7F
  } opcode_t;

  typedef enum logic [3:0] {
    FMOVA = 4'h0, FINC = 4'h1, FADD = 4'h2, FSUB = 4'h5,
    FDEC  = 4'h6, FAND = 4'h8, FOR  = 4'h9, FXOR = 4'hA,
    FNOT  = 4'hB, FMOVB = 4'hC, FSHR = 4'hD, FSHL = 4'hE,
    FCLR  = 4'hF
  } fs_t;

  cu_state_t   state_q;
  logic [IW-1:0] ir_q;

  logic [6:0]     op;
  logic [RAW-1:0] dr, sa, sb;
  logic           is_alu;

  assign op     = ir_q[IW-1 -: 7];
  assign dr     = ir_q[3*RAW-1 -: RAW];
  assign sa     = ir_q[2*RAW-1 -: RAW];
  assign sb     = ir_q[RAW-1:0];
  assign is_alu = (op[6:4] == 3'b000);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RST;
      ir_q    <= '0;
    end else begin
      unique case (state_q)
        S_RST: state_q <= S_INF;
        S_INF: begin
          ir_q    <= ir_in;
          state_q <= S_EX0;
        end
        S_EX0: begin
          if (op == OP_XXL)      state_q <= S_XL1;
          else if (op == OP_HAL) state_q <= S_HLT;
          else                   state_q <= S_INF;
        end
        S_XL1:   state_q <= S_INF;
        S_HLT:   state_q <= S_HLT;
        default: state_q <= S_RST;
      endcase
    end
  end

  logic [RAW-1:0] da_c, aa_c, ba_c;
  fs_t            fs_c;
  logic [1:0]     md_c;
  logic mb_c, rw_c, mm_c, mw_c, io_c;
  logic pi_c, pl_c, jb_c, hlt_c, ill_c;

  always_comb begin
    da_c  = '0;
    aa_c  = '0;
    ba_c  = '0;
    fs_c  = FMOVA;
    md_c  = 2'b00;
    mb_c  = 1'b0;
    rw_c  = 1'b0;
    mm_c  = 1'b0;
    mw_c  = 1'b0;
    io_c  = 1'b0;
    pi_c  = 1'b0;
    pl_c  = 1'b0;
    jb_c  = 1'b0;
    hlt_c = 1'b0;
    ill_c = 1'b0;
    unique case (state_q)
      S_INF: mm_c = 1'b1;
      S_EX0: begin
        da_c = dr;
        aa_c = sa;
        ba_c = sb;
        unique case (1'b1)
          is_alu: begin
            fs_c = fs_t'(op[3:0]);
            rw_c = 1'b1;
            pi_c = 1'b1;
          end
          (op == OP_LDI): begin
            fs_c = FMOVB;
            mb_c = 1'b1;
            rw_c = 1'b1;
            pi_c = 1'b1;
          end
          (op == OP_ADI): begin
            fs_c = FADD;
            mb_c = 1'b1;
            rw_c = 1'b1;
            pi_c = 1'b1;
          end
          (op == OP_LD): begin
            md_c = 2'b01;
            rw_c = 1'b1;
            pi_c = 1'b1;
          end
          (op == OP_ST): begin
            mw_c = 1'b1;
            pi_c = 1'b1;
          end
          (op == OP_IOR): begin
            md_c = 2'b10;
            rw_c = 1'b1;
            pi_c = 1'b1;
          end
          (op == OP_IOW): begin
            io_c = 1'b1;
            pi_c = 1'b1;
          end
          (op == OP_BRZ): begin
            pl_c = z_in;
            pi_c = ~z_in;
          end
          (op == OP_BRN): begin
            pl_c = n_in;
            pi_c = ~n_in;
          end
          (op == OP_JMP): begin
            pl_c = 1'b1;
            jb_c = 1'b1;
          end
          (op == OP_HAL): begin
          end
          (op == OP_XXL): begin
            fs_c = FXOR;
            rw_c = 1'b1;
          end
          default: begin
            ill_c = 1'b1;
            pi_c  = 1'b1;
          end
        endcase
      end
      // second half of XXL: invert the XOR result in place
      S_XL1: begin
        aa_c = dr;
        da_c = dr;
        fs_c = FNOT;
        rw_c = 1'b1;
        pi_c = 1'b1;
      end
      S_HLT:   hlt_c = 1'b1;
      default: begin
      end
    endcase
  end

  assign da        = da_c;
  assign aa        = aa_c;
  assign ba        = ba_c;
  assign mb        = mb_c;
  assign fs        = fs_c;
  assign md        = md_c;
  assign mm        = mm_c;
  assign jb        = jb_c;
  assign halted    = hlt_c;
  assign ill_op    = ill_c;
  assign state_out = state_q;
  // writes are suppressed the moment reset asserts, ahead of the edge
  assign rw        = rw_c & rst_n;
  assign mw        = mw_c & rst_n;
  assign io_we     = io_c & rst_n;
  assign pi        = pi_c & rst_n;
  assign pl        = pl_c & rst_n;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed per-cycle vectors queued by
// the stimulus, checked by an independent negedge monitor.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ir_in = '0;
  logic        z_in = 1'b0;
  logic        n_in = 1'b0;
  logic [2:0]  da, aa, ba;
  logic        mb, rw, mm, mw, io_we, pi, pl, jb, halted, ill_op;
  logic [3:0]  fs, state_out;
  logic [1:0]  md;

  control_unit #(.IW(16), .RAW(3)) dut (
    .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .z_in(z_in), .n_in(n_in),
    .da(da), .aa(aa), .ba(ba), .mb(mb), .fs(fs), .md(md), .rw(rw),
    .mm(mm), .mw(mw), .io_we(io_we), .pi(pi), .pl(pl), .jb(jb),
    .halted(halted), .ill_op(ill_op), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [28:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // {state,da,aa,ba,mb,fs,md,rw,mm,mw,io_we,pi,pl,jb,halted,ill_op}
  function automatic logic [28:0] mk(
    input logic [3:0] st, input logic [2:0] d, input logic [2:0] a,
    input logic [2:0] b, input logic m, input logic [3:0] f,
    input logic [1:0] mdv, input logic r, input logic mmv,
    input logic mwv, input logic io, input logic p, input logic l,
    input logic j, input logic h, input logic il);
    return {st, d, a, b, m, f, mdv, r, mmv, mwv, io, p, l, j, h, il};
  endfunction

  logic [28:0] obs;
  assign obs = {state_out, da, aa, ba, mb, fs, md, rw, mm, mw, io_we,
                pi, pl, jb, halted, ill_op};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (obs !== e.v) begin
        fails++;
        $display("FAIL %s: got %h required %h", e.name, obs, e.v);
      end
    end
  end

  task automatic step(input string nm, input logic r, input logic [15:0] ir,
                      input logic z, input logic n, input logic [28:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = r;
    ir_in = ir;
    z_in  = z;
    n_in  = n;
    x.v    = e;
    x.name = nm;
    q.push_back(x);
  endtask

  logic [28:0] RSTV, INFV, HLTV;

  initial begin
    RSTV = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    INFV = mk(1,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0);
    HLTV = mk(4,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0);

    step("rst_hold",    0, 16'h4000, 0, 0, RSTV);
    step("rst_release", 1, 16'h4000, 0, 0, RSTV);
    step("inf_first",   1, 16'h4000, 0, 0, INFV);
    step("st_ex0",      1, 16'h4000, 0, 0,
         mk(2,0,0,0,0,0,0,0,0,1,0,1,0,0,0,0));
    step("inf_st2",     1, 16'h4000, 0, 0, INFV);
    step("st_ex0_rstlo",0, 16'h4000, 0, 0,
         mk(2,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    step("rst_mid_ex0", 0, 16'h04CA, 0, 0, RSTV);
    step("rst_one_cyc", 1, 16'h04CA, 0, 0, RSTV);
    step("inf_add",     1, 16'h04CA, 0, 0, INFV);
    step("add_ex0",     1, 16'h9845, 0, 0,
         mk(2,3,1,2,0,4'h2,0,1,0,0,0,1,0,0,0,0));
    step("inf_ldi",     1, 16'h9845, 0, 0, INFV);
    step("ldi_ex0",     1, 16'hC008, 1, 0,
         mk(2,1,0,5,1,4'hC,0,1,0,0,0,1,0,0,0,0));
    step("inf_brz",     1, 16'hC008, 1, 0, INFV);
    step("brz_taken",   1, 16'hC008, 1, 0,
         mk(2,0,1,0,0,0,0,0,0,0,0,0,1,0,0,0));
    step("inf_brz2",    1, 16'hC008, 0, 0, INFV);
    step("brz_not",     1, 16'hE008, 0, 0,
         mk(2,0,1,0,0,0,0,0,0,0,0,1,0,0,0,0));
    step("inf_jmp",     1, 16'hE008, 0, 0, INFV);
    step("jmp_ex0",     1, 16'hFC8B, 0, 0,
         mk(2,0,1,0,0,0,0,0,0,0,0,0,1,1,0,0));
    step("inf_xxl",     1, 16'hFC8B, 0, 0, INFV);
    step("xxl_ex0",     1, 16'h7E00, 0, 0,
         mk(2,2,1,3,0,4'hA,0,1,0,0,0,0,0,0,0,0));
    step("xxl_xl1",     1, 16'h7E00, 0, 0,
         mk(3,2,2,0,0,4'hB,0,1,0,0,0,1,0,0,0,0));
    step("inf_ill",     1, 16'h7E00, 0, 0, INFV);
    step("ill_ex0",     1, 16'h2240, 0, 0,
         mk(2,0,0,0,0,0,0,0,0,0,0,1,0,0,0,1));
    step("inf_ior",     1, 16'h2240, 0, 0, INFV);
    step("ior_ex0",     1, 16'h4208, 0, 0,
         mk(2,1,0,0,0,0,2'b10,1,0,0,0,1,0,0,0,0));
    step("inf_iow",     1, 16'h4208, 0, 0, INFV);
    step("iow_ex0",     1, 16'hFE00, 0, 0,
         mk(2,0,1,0,0,0,0,0,0,0,1,1,0,0,0,0));
    step("inf_hal",     1, 16'hFE00, 0, 0, INFV);
    step("hal_ex0",     1, 16'h04CA, 0, 0,
         mk(2,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 10; i++)
      step("hlt_hold",  1, 16'h04CA ^ 16'(i), 1, 1, HLTV);
    step("hlt_rst_lo",  0, 16'hC208, 0, 0, HLTV);
    step("hlt_to_rst",  1, 16'hC208, 0, 0, RSTV);
    step("inf_brn",     1, 16'hC208, 0, 1, INFV);
    step("brn_taken",   1, 16'h84CA, 0, 1,
         mk(2,0,1,0,0,0,0,0,0,0,0,0,1,0,0,0));
    step("inf_adi",     1, 16'h84CA, 0, 0, INFV);
    step("adi_ex0",     1, 16'h84CA, 0, 0,
         mk(2,3,1,2,1,4'h2,0,1,0,0,0,1,0,0,0,0));

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
